pwm_channel: RTL and testbench



---
 rtl/pwm_pkg.sv | 5 +
 rtl/pwm_channel.sv | 69 ++++++
 tb/tb_pwm_channel.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM constants and types used by the channel and the register-map code.
package pwm_pkg;
  localparam int CNT_WIDTH = 32;
  typedef logic [CNT_WIDTH-1:0] cnt_t;
endpackage

// File: rtl/pwm_channel.sv
// Single-channel PWM generator. Period and duty are shadowed and only picked up
// at a period boundary (or whenever the channel is idle), so a host write never
// truncates or glitches the period in flight. Polarity is applied after the
// register so it takes effect immediately.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_WIDTH = pwm_pkg::CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic [CNT_WIDTH-1:0] duty_cycle,
  input  logic                 polarity,
  output logic                 out
);

  localparam logic [CNT_WIDTH-1:0] ONE = 1;

  logic [CNT_WIDTH-1:0] cnt_q,    cnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] duty_q,   duty_d;
  logic                 raw_q,    raw_d;

  // Next-state: idle tracks the inputs, running counts and reloads at the wrap.
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    duty_d   = duty_q;
    raw_d    = raw_q;
    if (!en || period_q == '0) begin
      // Halted, or a zero period: hold the output inactive and keep the shadows
      // following the host so the next start uses fresh values.
      cnt_d    = '0;
      raw_d    = 1'b0;
      period_d = period;
      duty_d   = duty_cycle;
    end else begin
      // duty >= period naturally yields 100% since cnt never reaches period.
      raw_d = (cnt_q < duty_q);
      if (cnt_q == period_q - ONE) begin
        cnt_d    = '0;
        period_d = period;
        duty_d   = duty_cycle;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  // State register with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      period_q <= '0;
      duty_q   <= '0;
      raw_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      raw_q    <= raw_d;
    end
  end

  assign out = raw_q ^ polarity;

endmodule

// File: tb/tb_pwm_channel.sv
// Directed + randomized checks of pwm_channel against a period-position model.
module tb_pwm_channel;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, polarity, out;
  logic [31:0] period, duty_cycle;
  logic        en8, out8;
  logic [7:0]  period8, duty8;

  int tests = 0;
  int fails = 0;

  pwm_channel dut (
    .clk(clk), .rst(rst), .en(en), .period(period), .duty_cycle(duty_cycle),
    .polarity(polarity), .out(out)
  );

  pwm_channel #(.CNT_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .period(period8), .duty_cycle(duty8),
    .polarity(1'b0), .out(out8)
  );

  // Model: position inside the current period plus the settings latched for it.
  // The output is "active" while the position lies in the first min(duty,period)
  // slots of a running period.
  logic [31:0] m_pos, m_per, m_duty;
  logic        m_act;

  task automatic model_edge();
    logic [31:0] hi_len;
    if (rst) begin
      m_pos = 0; m_per = 0; m_duty = 0; m_act = 1'b0;
    end else if (!en || m_per == 0) begin
      m_pos = 0; m_act = 1'b0; m_per = period; m_duty = duty_cycle;
    end else begin
      hi_len = (m_duty < m_per) ? m_duty : m_per;
      m_act  = (m_pos < hi_len);
      if (m_pos + 1 == m_per) begin
        m_pos = 0; m_per = period; m_duty = duty_cycle;
      end else begin
        m_pos = m_pos + 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag, out, m_act ^ polarity);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; polarity = 1'b0; period = 32'd10; duty_cycle = 32'd3;
    en8 = 1'b0; period8 = 8'd255; duty8 = 8'd128;
    m_pos = 0; m_per = 0; m_duty = 0; m_act = 1'b0;

    // 1: reset
    for (int i = 0; i < 3; i++) begin
      tick("reset_pol0");
      check("reset_pol0_const", out, 1'b0);
    end
    polarity = 1'b1; #1;
    check("reset_pol1", out, 1'b1);
    polarity = 1'b0;
    rst = 1'b0;
    tick("release");
    tests++;
    assert (dut.cnt_q === 32'd0) else begin
      fails++;
      $error("FAIL cnt_after_reset: observed=%0d expected=0", dut.cnt_q);
    end

    // 2: basic 3 high / 7 low, first high right after the enabling edge
    en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick("basic");
      check("basic_pattern", out, (i % 10) < 3);
    end

    // 4: mid-period duty change only visible from the next period
    for (int i = 0; i < 4; i++) tick("upd_pre");
    duty_cycle = 32'd7;
    for (int i = 4; i < 10; i++) begin
      tick("upd_cur");
      check("upd_cur_low", out, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      tick("upd_next");
      check("upd_next_pattern", out, i < 7);
    end

    // 5: enable drop mid-high, polarity immediate, clean restart
    tick("en_high");
    check("en_high_val", out, 1'b1);
    en = 1'b0;
    tick("en_drop");
    check("en_drop_val", out, 1'b0);
    polarity = 1'b1; #1;
    check("pol_immediate", out, 1'b1);
    polarity = 1'b0; #1;
    check("pol_back", out, 1'b0);
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick("reenable");
      check("reenable_pattern", out, i < 7);
    end

    // 3: extremes (idle one cycle so the shadows pick up the new values)
    en = 1'b0; period = 32'd10; duty_cycle = 32'd0; tick("ext_idle0");
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin tick("duty0"); check("duty0_val", out, 1'b0); end
    en = 1'b0; duty_cycle = 32'd10; tick("ext_idle1");
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin tick("duty_eq"); check("duty_eq_val", out, 1'b1); end
    en = 1'b0; duty_cycle = 32'd25; tick("ext_idle2");
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin tick("duty_gt"); check("duty_gt_val", out, 1'b1); end
    en = 1'b0; period = 32'd0; duty_cycle = 32'd5; tick("ext_idle3");
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin tick("period0"); check("period0_val", out, 1'b0); end
    en = 1'b0; period = 32'd1; duty_cycle = 32'd1; tick("ext_idle4");
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin tick("period1"); check("period1_val", out, 1'b1); end

    // randomized operation against the model
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) period = $urandom_range(0, 12);
      if ($urandom_range(0, 7) == 0) duty_cycle = $urandom_range(0, 15);
      if ($urandom_range(0, 19) == 0) en = ~en;
      if ($urandom_range(0, 15) == 0) polarity = ~polarity;
      rst = ($urandom_range(0, 59) == 0);
      tick("random");
    end
    rst = 1'b0; polarity = 1'b0;

    // 6: large values on the 32-bit channel
    en = 1'b0; period = 32'hFFFF_FFFF; duty_cycle = 32'h8000_0000; tick("big_idle");
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin tick("big"); check("big_high", out, 1'b1); end

    // Full-range wrap on an 8-bit channel: period at max, duty at half scale.
    en8 = 1'b1;
    for (int i = 0; i < 520; i++) begin
      @(posedge clk); #1;
      check("wrap8", out8, (i % 255) < 128);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
